// File: rtl/bus_responder.sv
// bus_responder: target-side end of the interface bus.
// Decodes OP/Direction/Data and serves byte reads and writes from a local memory
// window and a four-port I/O block. WAIT_CYCLES wait states are inserted, and then
// the result is returned with a one-cycle ready pulse.
// Optional feature: define ACCESS_COUNT_EN to add an 8-bit counter of completed
// transactions. The counter is readable through I/O port 3. Without the macro,
// port 3 reads 8'h00 and the design contains no counter logic.
module bus_responder #(
    parameter int          MEM_AW      = 12,
    parameter logic [19:0] MEM_BASE    = 20'h00000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  OP,
    input  logic [19:0] Direction,
    input  logic [7:0]  Data,
    output logic [7:0]  Data_rd,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_MEM_RD = 3'b001;
    localparam logic [2:0] OP_MEM_WR = 3'b010;
    localparam logic [2:0] OP_IO_RD  = 3'b011;
    localparam logic [2:0] OP_IO_WR  = 3'b100;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [2:0]  op_q;
    logic [19:0] dir_q;
    logic [7:0]  data_q;
    logic [7:0]  p0;
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic [7:0]  mem [0:(1 << MEM_AW) - 1];

    logic [2:0]  req_op;
    logic [19:0] req_dir;
    logic        mem_hit;
    logic        io_hit;
    logic [1:0]  io_port;
    logic [7:0]  p3_value;
    logic [7:0]  resp_data;
    logic        resp_err;
    logic        mem_we;

`ifdef ACCESS_COUNT_EN
    logic [7:0]  access_count;
    assign p3_value = access_count;
`else
    assign p3_value = 8'h00;
`endif

    // The response is decoded from the live inputs while idle (needed when there are zero wait states) and from the latched request otherwise
    always_comb begin
        req_op  = op_q;
        req_dir = dir_q;
        if (state == S_IDLE) begin
            req_op  = OP;
            req_dir = Direction;
        end
    end

    assign mem_hit = (req_dir[19:MEM_AW] == MEM_BASE[19:MEM_AW]);
    assign io_hit  = (req_dir[15:2] == 14'd0);
    assign io_port = req_dir[1:0];
    assign mem_we  = (state == S_RESP) && (op_q == OP_MEM_WR) && mem_hit;

    // Compute the read data and error flag that the request will present in its response cycle
    always_comb begin
        resp_data = 8'hFF;
        resp_err  = 1'b1;
        case (req_op)
            OP_MEM_RD: begin
                if (mem_hit) begin
                    resp_data = mem[req_dir[MEM_AW-1:0]];
                    resp_err  = 1'b0;
                end
            end
            OP_MEM_WR: begin
                if (mem_hit) begin
                    resp_data = 8'h00;
                    resp_err  = 1'b0;
                end
            end
            OP_IO_RD: begin
                if (io_hit) begin
                    resp_err = 1'b0;
                    case (io_port)
                        2'd0:    resp_data = p0;
                        2'd1:    resp_data = p1;
                        2'd2:    resp_data = p2;
                        default: resp_data = p3_value;
                    endcase
                end
            end
            OP_IO_WR: begin
                if (io_hit) begin
                    resp_data = 8'h00;
                    resp_err  = 1'b0;
                end
            end
            default: begin
                resp_data = 8'hFF;
                resp_err  = 1'b1;
            end
        endcase
    end

    // Memory writes commit at the clock edge that ends the response cycle; the contents are never reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[dir_q[MEM_AW-1:0]] <= data_q;
        end
    end

    // Handshake FSM: accept, count wait states, and emit a single registered ready/err/Data_rd pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            op_q     <= OP_NOP;
            dir_q    <= 20'd0;
            data_q   <= 8'd0;
            Data_rd  <= 8'd0;
            ready    <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            p0       <= 8'd0;
            p1       <= 8'd0;
            p2       <= 8'd0;
`ifdef ACCESS_COUNT_EN
            access_count <= 8'd0;
`endif
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (OP != OP_NOP) begin
                        op_q   <= OP;
                        dir_q  <= Direction;
                        data_q <= Data;
                        busy   <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state   <= S_RESP;
                            ready   <= 1'b1;
                            err     <= resp_err;
                            Data_rd <= resp_data;
                        end else begin
                            wait_cnt <= WAIT_LOAD;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt <= 4'd1) begin
                        state   <= S_RESP;
                        ready   <= 1'b1;
                        err     <= resp_err;
                        Data_rd <= resp_data;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    Data_rd <= 8'd0;
                    if ((op_q == OP_IO_WR) && io_hit) begin
                        case (io_port)
                            2'd0:    p0 <= data_q;
                            2'd1:    p1 <= data_q;
                            2'd2:    p2 <= data_q;
                            default: p2 <= p2;
                        endcase
                    end
`ifdef ACCESS_COUNT_EN
                    access_count <= access_count + 8'd1;
`endif
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: randomized and directed bench for bus_responder.
// A behavioural model tracks the memory, I/O ports and access count.
// Define ACCESS_COUNT_EN for both bench and design to exercise the counter.
module tb_bus_responder;

    localparam int          AW      = 12;
    localparam logic [19:0] BASE    = 20'h00000;
    localparam int          WAITS   = 2;
    localparam int          EXP_LAT = 1 + WAITS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  OP = 3'b000;
    logic [19:0] Direction = 20'd0;
    logic [7:0]  Data = 8'd0;
    logic [7:0]  Data_rd;
    logic        ready;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_model [4096];
    bit         mem_known [4096];
    logic [7:0] io_model [3];
    logic [7:0] count_model;

    bus_responder #(
        .MEM_AW      (AW),
        .MEM_BASE    (BASE),
        .WAIT_CYCLES (WAITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .OP        (OP),
        .Direction (Direction),
        .Data      (Data),
        .Data_rd   (Data_rd),
        .ready     (ready),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reset clears the ports and the counter but leaves the memory model untouched
    task automatic model_reset();
        for (int i = 0; i < 3; i++) io_model[i] = 8'h00;
        count_model = 8'h00;
    endtask

    // Reference behaviour of one completed transaction
    task automatic model_txn(input logic [2:0] op, input logic [19:0] dir, input logic [7:0] data,
                             output logic [7:0] xd, output logic xe, output bit known);
        bit in_win;
        int off;
        int port;
        logic [7:0] p3;
        in_win = (int'(dir) / 4096) == (int'(BASE) / 4096);
        off    = int'(dir) % 4096;
        port   = int'(dir) % 65536;
`ifdef ACCESS_COUNT_EN
        p3 = count_model;
`else
        p3 = 8'h00;
`endif
        xd = 8'hFF;
        xe = 1'b1;
        known = 1'b1;
        case (op)
            3'd1: if (in_win) begin xd = mem_model[off]; known = mem_known[off]; xe = 1'b0; end
            3'd2: if (in_win) begin mem_model[off] = data; mem_known[off] = 1'b1; xd = 8'h00; xe = 1'b0; end
            3'd3: if (port < 4) begin xd = (port == 3) ? p3 : io_model[port]; xe = 1'b0; end
            3'd4: if (port < 4) begin if (port < 3) io_model[port] = data; xd = 8'h00; xe = 1'b0; end
            default: ;
        endcase
        count_model = count_model + 8'd1;
    endtask

    // Presents one request for a single cycle and waits (bounded) for its ready pulse
    task automatic run_txn(input logic [2:0] op, input logic [19:0] dir, input logic [7:0] data,
                           output logic [7:0] d, output logic e, output int lat, output bit busy_ok);
        @(negedge clk);
        OP = op;
        Direction = dir;
        Data = data;
        @(posedge clk);
        #1;
        OP = 3'b000;
        Direction = 20'($urandom);
        Data = 8'($urandom);
        lat = -1;
        busy_ok = 1'b1;
        d = 8'h00;
        e = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (ready === 1'b1) begin
                lat = i;
                d = Data_rd;
                e = err;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({Data_rd, ready, err, busy} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 000", {Data_rd, ready, err, busy});
        end
        reset = 1'b0;
    endtask

    task automatic test_mem();
        logic [2:0]  ops [8]  = '{3'd2, 3'd1, 3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd1};
        logic [19:0] dirs [8] = '{20'h00010, 20'h00010, 20'h01000, 20'h01010, 20'h00010, 20'h00FFF, 20'h00FFF, 20'hFFFFF};
        logic [7:0]  dats [8] = '{8'hA5, 8'h00, 8'h00, 8'h11, 8'h00, 8'h5E, 8'h00, 8'h00};
        logic [7:0]  xds [8]  = '{8'h00, 8'hA5, 8'hFF, 8'hFF, 8'hA5, 8'h00, 8'h5E, 8'hFF};
        logic        xes [8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] d, md;
        logic e, me;
        int lat;
        bit bok, kn;
        for (int i = 0; i < 8; i++) begin
            run_txn(ops[i], dirs[i], dats[i], d, e, lat, bok);
            model_txn(ops[i], dirs[i], dats[i], md, me, kn);
            checks++;
            if (d !== xds[i] || e !== xes[i] || lat != EXP_LAT || !bok) begin
                errors++;
                $display("[TB] FAIL mem_%0d: got data=%h err=%b lat=%0d busy_ok=%0d, expected data=%h err=%b lat=%0d busy_ok=1",
                         i, d, e, lat, bok, xds[i], xes[i], EXP_LAT);
            end
        end
    endtask

    task automatic test_io();
        logic [2:0]  ops [8]  = '{3'd3, 3'd4, 3'd3, 3'd3, 3'd4, 3'd4, 3'd3, 3'd3};
        logic [19:0] dirs [8] = '{20'h00000, 20'h00001, 20'h00001, 20'h00004, 20'h00003, 20'hF0002, 20'h00002, 20'h00100};
        logic [7:0]  dats [8] = '{8'h00, 8'h3C, 8'h00, 8'h00, 8'h99, 8'h47, 8'h00, 8'h00};
        logic [7:0]  xds [8]  = '{8'h00, 8'h00, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h47, 8'hFF};
        logic        xes [8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] d, md;
        logic e, me;
        int lat;
        bit bok, kn;
        for (int i = 0; i < 8; i++) begin
            run_txn(ops[i], dirs[i], dats[i], d, e, lat, bok);
            model_txn(ops[i], dirs[i], dats[i], md, me, kn);
            checks++;
            if (d !== xds[i] || e !== xes[i] || lat != EXP_LAT || !bok) begin
                errors++;
                $display("[TB] FAIL io_%0d: got data=%h err=%b lat=%0d busy_ok=%0d, expected data=%h err=%b lat=%0d busy_ok=1",
                         i, d, e, lat, bok, xds[i], xes[i], EXP_LAT);
            end
        end
    endtask

    task automatic test_illegal();
        logic [2:0] ops [4] = '{3'd5, 3'd6, 3'd7, 3'd1};
        logic [7:0] xds [4] = '{8'hFF, 8'hFF, 8'hFF, 8'hA5};
        logic       xes [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0] d, md;
        logic e, me;
        int lat;
        bit bok, kn;
        for (int i = 0; i < 4; i++) begin
            run_txn(ops[i], 20'h00010, 8'h42, d, e, lat, bok);
            model_txn(ops[i], 20'h00010, 8'h42, md, me, kn);
            checks++;
            if (d !== xds[i] || e !== xes[i] || lat != EXP_LAT || !bok) begin
                errors++;
                $display("[TB] FAIL illegal_%0d: got data=%h err=%b lat=%0d busy_ok=%0d, expected data=%h err=%b lat=%0d busy_ok=1",
                         i, d, e, lat, bok, xds[i], xes[i], EXP_LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] busy_v = 8'h00;
        logic [7:0] ready_v = 8'h00;
        logic [7:0] d1 = 8'h00;
        logic [7:0] d2 = 8'h00;
        logic [7:0] md;
        logic me;
        bit kn;
        @(negedge clk);
        OP = 3'd1;
        Direction = 20'h00010;
        @(posedge clk);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            busy_v[8-i] = busy;
            ready_v[8-i] = ready;
            if (i == 3) d1 = Data_rd;
            if (i == 7) d2 = Data_rd;
            if (i == 5) OP = 3'd0;
        end
        model_txn(3'd1, 20'h00010, 8'h00, md, me, kn);
        model_txn(3'd1, 20'h00010, 8'h00, md, me, kn);
        checks++;
        if (busy_v !== 8'b1110_1110) begin
            errors++;
            $display("[TB] FAIL b2b_busy: got %b expected 11101110", busy_v);
        end
        checks++;
        if (ready_v !== 8'b0010_0010) begin
            errors++;
            $display("[TB] FAIL b2b_ready: got %b expected 00100010", ready_v);
        end
        checks++;
        if ({d1, d2} !== {md, md}) begin
            errors++;
            $display("[TB] FAIL b2b_data: got %h %h expected %h %h", d1, d2, md, md);
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] d, md;
        logic e, me;
        int lat;
        bit bok, kn;
        run_txn(3'd2, 20'h00020, 8'h5A, d, e, lat, bok);
        model_txn(3'd2, 20'h00020, 8'h5A, md, me, kn);
        @(negedge clk);
        OP = 3'd2;
        Direction = 20'h00020;
        Data = 8'h77;
        @(posedge clk);
        #1;
        OP = 3'd0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({Data_rd, ready, err, busy} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got %h expected 000", {Data_rd, ready, err, busy});
        end
        @(negedge clk);
        reset = 1'b0;
        run_txn(3'd1, 20'h00020, 8'h00, d, e, lat, bok);
        model_txn(3'd1, 20'h00020, 8'h00, md, me, kn);
        checks++;
        if (d !== 8'h5A || e !== 1'b0 || lat != EXP_LAT) begin
            errors++;
            $display("[TB] FAIL abort_mem: got data=%h err=%b lat=%0d expected data=5a err=0 lat=%0d", d, e, lat, EXP_LAT);
        end
        run_txn(3'd3, 20'h00001, 8'h00, d, e, lat, bok);
        model_txn(3'd3, 20'h00001, 8'h00, md, me, kn);
        checks++;
        if (d !== 8'h00 || e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_port1: got data=%h err=%b expected data=00 err=0", d, e);
        end
    endtask

    task automatic test_p3();
        logic [7:0] d, md, exp_p3;
        logic e, me;
        int lat;
        bit bok, kn;
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            run_txn(3'd3, 20'h00000, 8'h00, d, e, lat, bok);
            model_txn(3'd3, 20'h00000, 8'h00, md, me, kn);
        end
`ifdef ACCESS_COUNT_EN
        exp_p3 = 8'h03;
`else
        exp_p3 = 8'h00;
`endif
        run_txn(3'd3, 20'h00003, 8'h00, d, e, lat, bok);
        model_txn(3'd3, 20'h00003, 8'h00, md, me, kn);
        checks++;
        if (d !== exp_p3 || e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL p3_after_3: got data=%h err=%b expected data=%h err=0", d, e, exp_p3);
        end
`ifdef ACCESS_COUNT_EN
        for (int i = 0; i < 256; i++) begin
            run_txn(3'd3, 20'h00000, 8'h00, d, e, lat, bok);
            model_txn(3'd3, 20'h00000, 8'h00, md, me, kn);
        end
        run_txn(3'd3, 20'h00003, 8'h00, d, e, lat, bok);
        model_txn(3'd3, 20'h00003, 8'h00, md, me, kn);
        checks++;
        if (d !== 8'h04 || e !== 1'b0) begin
            errors++;
            $display("[TB] FAIL p3_wrap: got data=%h err=%b expected data=04 err=0", d, e);
        end
`endif
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [19:0] dir;
        logic [7:0]  dat, d, xd;
        logic e, xe;
        int lat;
        bit bok, kn;
        for (int i = 0; i < 200; i++) begin
            op  = 3'($urandom_range(1, 7));
            dat = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       dir = 20'($urandom_range(0, 15));
                1:       dir = 20'($urandom);
                2:       dir = {4'($urandom), 16'($urandom_range(0, 5))};
                default: dir = 20'h01000 + 20'($urandom_range(0, 15));
            endcase
            run_txn(op, dir, dat, d, e, lat, bok);
            model_txn(op, dir, dat, xd, xe, kn);
            checks++;
            if ((kn && d !== xd) || e !== xe || lat != EXP_LAT || !bok) begin
                errors++;
                $display("[TB] FAIL rand_%0d op=%0d dir=%h: got data=%h err=%b lat=%0d busy_ok=%0d, expected data=%h err=%b lat=%0d busy_ok=1",
                         i, op, dir, d, e, lat, bok, xd, xe, EXP_LAT);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem_model[i] = 8'h00;
            mem_known[i] = 1'b0;
        end
        model_reset();
        test_reset();
        test_mem();
        test_io();
        test_illegal();
        test_back_to_back();
        test_reset_abort();
        test_p3();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
